// File: rtl/edge_detect_multi.sv
// edge_detect_multi: synchronised multi-channel rise/fall/both edge detector with sticky flags; optional debounce under EDGE_DEBOUNCE_EN
module edge_detect_multi #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic [2*WIDTH-1:0]   mode,
  input  logic [WIDTH-1:0]     clear,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     sticky,
  output logic                 any_edge
);
  localparam int WU = SYNC_STAGES + 1;
  localparam int WW = $clog2(WU + 1);
  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("edge_detect_multi: illegal parameter value");
  end
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync;
  logic [WIDTH-1:0] lvl, f, prev, sel, out_next;
  logic [WW-1:0] wu;
  assign lvl = sync[SYNC_STAGES-1];
  always_ff @(posedge clock) begin
    if (reset) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], in};
  end
`ifdef EDGE_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [WIDTH-1:0][CW-1:0] cnt;
  always_ff @(posedge clock) begin
    if (reset) begin
      f   <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lvl[i] == f[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          f[i]   <= lvl[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`else
  assign f = lvl;
`endif
  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++)
      sel[i] = (mode[2*i] & f[i] & ~prev[i]) | (mode[2*i+1] & ~f[i] & prev[i]);
  end
  assign out_next = (wu == WW'(WU)) ? sel : '0;
  always_ff @(posedge clock) begin
    if (reset) begin
      prev   <= '0;
      out    <= '0;
      sticky <= '0;
      wu     <= '0;
    end else begin
      prev   <= f;
      out    <= out_next;
      sticky <= (sticky & ~clear) | out_next;
      wu     <= (wu == WW'(WU)) ? wu : wu + 1'b1;
    end
  end
  assign any_edge = |out;
endmodule

// File: tb/tb_edge_detect_multi.sv
// tb_edge_detect_multi: scoreboard bench for edge_detect_multi against a sample-history reference model
module tb_edge_detect_multi;
  localparam int W = 4;
  localparam int S = 2;
  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] s;
    logic         a;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] in = 4'b0011;
  logic [W-1:0] clear = '0;
  logic [2*W-1:0] mode = 8'hFF;
  logic [W-1:0] out, sticky;
  logic any_edge;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #20 clock = ~clock;
  edge_detect_multi #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .in(in), .mode(mode), .clear(clear),
    .out(out), .sticky(sticky), .any_edge(any_edge)
  );
  logic [W-1:0] h [S+2] = '{default: '0};
  logic [W-1:0] sm = '0;
  int n = 0;
  always @(posedge clock) begin
    logic [W-1:0] lv, pv, o;
    exp_t e;
    for (int j = S + 1; j > 0; j--) h[j] = h[j-1];
    h[0] = reset ? '0 : in;
    lv = h[S];
    pv = h[S+1];
    o = '0;
    for (int i = 0; i < W; i++)
      case (mode[2*i +: 2])
        2'b01:   o[i] = lv[i] & ~pv[i];
        2'b10:   o[i] = pv[i] & ~lv[i];
        2'b11:   o[i] = lv[i] ^ pv[i];
        default: o[i] = 1'b0;
      endcase
    if (reset) begin
      n = 0;
      o = '0;
      sm = '0;
    end else begin
      n++;
      if (n <= S + 1) o = '0;
      sm = (sm & ~clear) | o;
    end
    e.o = o;
    e.s = sm;
    e.a = |o;
    q.push_back(e);
  end
  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, req);
    end
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out", out, e.o);
      chk("sticky", sticky, e.s);
      chk("any_edge", W'(any_edge), W'(e.a));
    end
  end
  task automatic cyc(int k);
    repeat (k) @(negedge clock);
  endtask
  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(6);
    mode = 8'h55;
    in = 4'b0000;
    cyc(4);
    in[0] = 1'b1;
    cyc(4);
    mode = 8'h59;
    in[1] = 1'b1; cyc(4);
    in[1] = 1'b0; cyc(4);
    in[1] = 1'b1; cyc(4);
    mode = 8'h5D;
    in[1] = 1'b0; cyc(4);
    in[1] = 1'b1; cyc(4);
    in[2] = 1'b1; cyc(4);
    in[2] = 1'b0; cyc(4);
    in[2] = 1'b1; cyc(2);
    clear[2] = 1'b1; cyc(2);
    clear[2] = 1'b0; cyc(2);
    in[0] = 1'b0; cyc(4);
    in[0] = 1'b1; cyc(3);
    reset = 1'b1; cyc(1);
    reset = 1'b0; cyc(6);
    mode = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      in[3] = ~in[3];
      cyc(3);
    end
    in[3] = 1'b1;
    cyc(15);
    for (int t = 0; t < 400; t++) begin
      in = W'($urandom);
      if ($urandom_range(0, 15) == 0) mode = (2*W)'($urandom);
      clear = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      reset = ($urandom_range(0, 63) == 0);
      cyc(1);
    end
    reset = 1'b0;
    clear = '0;
    cyc(3);
    #1;
    chk("drain", W'(q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
